// File: rtl/block_binarizer.sv
// -----------------------------------------------------------------------------
// block_binarizer
//
// Purpose:
//   Takes a raster-order grayscale pixel stream for one IMG_W x IMG_H frame and
//   splits it into a grid of BLK x BLK blocks (8 x 6 with the default sizes).
//   Each block is summed and compared against a runtime threshold. The results
//   are packed into a 48-bit vector, with bit index = block_y*8 + block_x.
//   The vector is presented once per frame to the block-mosaic display stage.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   pix_valid  pixel qualifier; one pixel is accepted per cycle while high
//   pix_sof    start of frame; only meaningful with pix_valid; marks pixel (0,0)
//   pix_data   grayscale pixel
//   thresh     average-intensity threshold; sampled on each block's last pixel
//   vec_48     last completed binarized frame; it holds between updates
//   vec_valid  one-cycle pulse when vec_48 updates
//   busy       high while a frame is being accumulated
//
// Build option:
//   BLOCK_BINARIZER_INVERT_EN  when defined, a block bit is 1 if its sum is
//                              below the threshold product, so dark blocks are
//                              displayed white. Timing is the same in both
//                              builds.
// -----------------------------------------------------------------------------
module block_binarizer #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int BLK   = 20,
    parameter int PIX_W = 8,
    parameter int SUM_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic [PIX_W-1:0] pix_data,
    input  logic [PIX_W-1:0] thresh,
    output logic [47:0]      vec_48,
    output logic             vec_valid,
    output logic             busy
);

    localparam int NBX  = IMG_W / BLK;
    localparam int NBY  = IMG_H / BLK;
    localparam int X_W  = $clog2(IMG_W);
    localparam int Y_W  = $clog2(IMG_H);
    localparam int B_W  = $clog2(BLK);
    localparam int BX_W = $clog2(NBX);
    localparam int BY_W = $clog2(NBY);

    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMG_H - 1);
    localparam logic [B_W-1:0]   B_LAST   = B_W'(BLK - 1);
    localparam logic [BX_W-1:0]  BX_LAST  = BX_W'(NBX - 1);
    localparam logic [BY_W-1:0]  BY_LAST  = BY_W'(NBY - 1);
    localparam logic [SUM_W-1:0] BLK_AREA = SUM_W'(BLK * BLK);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t state;
    state_t next_state;

    // Position of the next pixel to be accepted. The in-block offsets and the
    // block indices are kept as separate counters so that no divider is needed.
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [B_W-1:0]  x_in_blk;
    logic [B_W-1:0]  y_in_blk;
    logic [BX_W-1:0] bx;
    logic [BY_W-1:0] by;

    // There is one running sum per block column. It is shared by all block rows
    // because a block row finishes before the next one starts.
    logic [SUM_W-1:0] acc [NBX];
    logic [47:0]      shadow;
    logic [47:0]      shadow_upd;

    logic             in_accum;
    logic             frame_last;
    logic             blk_last;
    logic             restart;
    logic             advance;
    logic [SUM_W-1:0] blk_sum;
    logic [SUM_W-1:0] thr_prod;
    logic             blk_bit;

    assign in_accum   = (state == ACCUM);
    assign frame_last = (x == X_LAST) && (y == Y_LAST);
    assign blk_last   = (x_in_blk == B_LAST) && (y_in_blk == B_LAST);

    // A frame-completing pixel is never a restart, even when pix_sof is high.
    assign restart  = pix_valid && pix_sof && !(in_accum && frame_last);
    assign advance  = pix_valid && in_accum && !restart;

    assign blk_sum  = acc[bx] + SUM_W'(pix_data);
    // Comparing the sum against thresh*BLK*BLK is the same as comparing the
    // block average against thresh, and it avoids a divide.
    assign thr_prod = SUM_W'(thresh) * BLK_AREA;

`ifdef BLOCK_BINARIZER_INVERT_EN
    assign blk_bit  = (blk_sum < thr_prod);
`else
    assign blk_bit  = (blk_sum >= thr_prod);
`endif

    assign busy = in_accum;

    // The shadow vector with the current block's bit merged in. On the final
    // pixel this is exactly what goes out, so vec_48 is never partially updated.
    always_comb begin
        // NOTE: Assign every always_comb output a default first. If any path
        // leaves an output unassigned, a latch is inferred.
        shadow_upd = shadow;
        if (blk_last) begin
            shadow_upd[{by, bx}] = blk_bit;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (pix_valid && pix_sof) next_state = ACCUM;
            ACCUM:   if (pix_valid && frame_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: Sequential state uses non-blocking assignments only. Every register
    // then samples values from before the edge, whatever order the code is in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            x_in_blk  <= '0;
            y_in_blk  <= '0;
            bx        <= '0;
            by        <= '0;
            shadow    <= '0;
            vec_48    <= '0;
            vec_valid <= 1'b0;
            // NOTE: The accumulators are a few flops, not a RAM, so they are
            // cleared by reset. A reset in the middle of a frame must not leave
            // partial sums behind.
            for (int i = 0; i < NBX; i++) begin
                acc[i] <= '0;
            end
        end else begin
            vec_valid <= 1'b0;

            if (restart) begin
                // This pixel becomes (0,0) of a fresh frame. Any partial frame
                // is dropped, and vec_48 is left untouched.
                for (int i = 0; i < NBX; i++) begin
                    acc[i] <= '0;
                end
                acc[0]   <= SUM_W'(pix_data);
                shadow   <= '0;
                x        <= X_W'(1);
                x_in_blk <= B_W'(1);
                bx       <= '0;
                y        <= '0;
                y_in_blk <= '0;
                by       <= '0;
            end else if (advance) begin
                acc[bx] <= blk_last ? '0 : blk_sum;
                shadow  <= shadow_upd;

                if (x_in_blk == B_LAST) begin
                    x_in_blk <= '0;
                    bx       <= (bx == BX_LAST) ? '0 : bx + 1'b1;
                end else begin
                    x_in_blk <= x_in_blk + 1'b1;
                end

                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                    if (y_in_blk == B_LAST) begin
                        y_in_blk <= '0;
                        by       <= (by == BY_LAST) ? '0 : by + 1'b1;
                    end else begin
                        y_in_blk <= y_in_blk + 1'b1;
                    end
                end else begin
                    x <= x + 1'b1;
                end

                if (frame_last) begin
                    vec_48    <= shadow_upd;
                    vec_valid <= 1'b1;
                    shadow    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_binarizer.sv
// -----------------------------------------------------------------------------
// tb_block_binarizer
//
// Purpose:
//   Self-checking bench for block_binarizer. The stimulus process pushes the
//   expected frame vectors and status snapshots into queues, each tagged with
//   the cycle it applies to. A separate monitor on the falling edge pops the
//   queues and compares them against the DUT outputs.
//
// Ports: none (top-level bench).
//
// Build option:
//   BLOCK_BINARIZER_INVERT_EN  selects the expected vectors for the inverted
//                              polarity build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_block_binarizer;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int BLK   = 20;
    localparam int PIX_W = 8;
    localparam int N_PIX = IMG_W * IMG_H;

    // Checker: blocks with (bx+by) even are 0xFF, the others 0x00, thresh 0x80.
    //   Even block rows give byte 0x55 and odd rows give 0xAA, with byte 0 at
    //   the lsb.
    // Bands (one content/thresh pair per block row):
    //   row0 7F/7F -> 50800>=50800 -> 1     row1 7F/80 -> 50800<51200 -> 0
    //   row2 00/00 -> 0>=0 -> 1             row3 00/01 -> 0<400 -> 0
    //   row4 FF/FF -> 102000>=102000 -> 1   row5 checker/80 -> odd bx -> 0xAA
    // Restart: the frame is all 0xFF with thresh 0xFF, so every block is equal.
`ifdef BLOCK_BINARIZER_INVERT_EN
    localparam logic [47:0] EXP_CHECKER = 48'h55AA_55AA_55AA;
    localparam logic [47:0] EXP_BANDS   = 48'h5500_FF00_FF00;
    localparam logic [47:0] EXP_RESTART = 48'h0000_0000_0000;
`else
    localparam logic [47:0] EXP_CHECKER = 48'hAA55_AA55_AA55;
    localparam logic [47:0] EXP_BANDS   = 48'hAAFF_00FF_00FF;
    localparam logic [47:0] EXP_RESTART = 48'hFFFF_FFFF_FFFF;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_data;
    logic [PIX_W-1:0] thresh;
    logic [47:0]      vec_48;
    logic             vec_valid;
    logic             busy;

    block_binarizer #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .BLK  (BLK),
        .PIX_W(PIX_W),
        .SUM_W(17)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pix_valid(pix_valid),
        .pix_sof  (pix_sof),
        .pix_data (pix_data),
        .thresh   (thresh),
        .vec_48   (vec_48),
        .vec_valid(vec_valid),
        .busy     (busy)
    );

    typedef struct {
        int          cyc;
        logic [47:0] vec;
    } out_exp_t;

    typedef struct {
        int          cyc;
        string       name;
        logic [47:0] vec;
        logic        busy;
        logic        valid;
    } stat_exp_t;

    out_exp_t    out_q[$];
    stat_exp_t   stat_q[$];
    out_exp_t    oe;
    stat_exp_t   se;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [47:0] last_vec;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every comparison happens here, on the falling edge.
    always @(negedge clk) begin
        if (vec_valid) begin
            if (out_q.size() == 0) begin
                check("vec_valid with nothing pending", {47'd0, vec_valid}, 48'd0);
            end else begin
                oe = out_q.pop_front();
                check("vec_48", vec_48, oe.vec);
                check("vec_valid cycle", 48'(cyc), 48'(oe.cyc));
            end
        end
        if (out_q.size() > 0 && out_q[0].cyc < cyc) begin
            oe = out_q.pop_front();
            check("vec_valid missing", {47'd0, vec_valid}, 48'd1);
        end
        while (stat_q.size() > 0 && stat_q[0].cyc <= cyc) begin
            se = stat_q.pop_front();
            check({se.name, " vec_48"}, vec_48, se.vec);
            check({se.name, " busy"}, {47'd0, busy}, {47'd0, se.busy});
            check({se.name, " vec_valid"}, {47'd0, vec_valid}, {47'd0, se.valid});
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_status(input int at, input string name, input logic [47:0] v,
                                 input logic b, input logic vv);
        stat_q.push_back('{at, name, v, b, vv});
    endtask

    function automatic logic [PIX_W-1:0] pix_of(input int mode, input int x, input int y);
        int          bxi;
        int          byi;
        logic [7:0]  chk;
        bxi = x / BLK;
        byi = y / BLK;
        chk = ((bxi + byi) % 2 == 0) ? 8'hFF : 8'h00;
        case (mode)
            0:       return 8'hFF;
            1:       return chk;
            default: begin
                case (byi)
                    0, 1:    return 8'h7F;
                    2, 3:    return 8'h00;
                    4:       return 8'hFF;
                    default: return chk;
                endcase
            end
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] thr_of(input int mode, input int y, input logic [7:0] base);
        if (mode != 2) return base;
        case (y / BLK)
            0:       return 8'h7F;
            1:       return 8'h80;
            2:       return 8'h00;
            3:       return 8'h01;
            4:       return 8'hFF;
            default: return 8'h80;
        endcase
    endfunction

    // Drives n pixels in raster order, starting at (0,0) with pix_sof.
    // Modes: 0 = all 0xFF, 1 = checker, 2 = bands (thresh set per block row).
    task automatic run_pixels(input int mode, input int n, input logic [7:0] thr,
                              input bit bubbles, input bit sof_last, input bit completes,
                              input logic [47:0] exp_vec);
        int x;
        int y;
        int gap;
        for (int i = 0; i < n; i++) begin
            x   = i % IMG_W;
            y   = i / IMG_W;
            gap = (bubbles && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
            for (int g = 0; g < gap; g++) begin
                tick();
                pix_valid = 1'b0;
                pix_sof   = 1'($urandom_range(1));
                pix_data  = 8'($urandom_range(255));
                thresh    = 8'($urandom_range(255));
            end
            tick();
            pix_valid = 1'b1;
            pix_sof   = (i == 0) || (sof_last && i == n - 1);
            pix_data  = pix_of(mode, x, y);
            thresh    = thr_of(mode, y, thr);
            if (i == 100) expect_status(cyc, "mid-frame", last_vec, 1'b1, 1'b0);
        end
        if (completes) begin
            // The last pixel is sampled at the next edge and vec_valid follows it.
            out_q.push_back('{cyc + 1, exp_vec});
            expect_status(cyc + 1, "frame end", exp_vec, 1'b0, 1'b1);
            last_vec = exp_vec;
        end
        tick();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = '0;
        thresh    = '0;
        last_vec  = '0;

        tick();
        tick();
        expect_status(cyc, "reset", 48'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        repeat (3) tick();

        // Checker frame, with pix_sof also on the final pixel: completion wins.
        run_pixels(1, N_PIX, 8'h80, 1'b0, 1'b1, 1'b1, EXP_CHECKER);

        // While idle, pixels without pix_sof are ignored.
        for (int i = 0; i < 50; i++) begin
            tick();
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_data  = 8'hFF;
        end
        tick();
        pix_valid = 1'b0;
        expect_status(cyc, "idle junk", last_vec, 1'b0, 1'b0);

        // Band frame with random bubbles: threshold equality, zero and max sums,
        // and a per-block-row thresh change.
        run_pixels(2, N_PIX, 8'h00, 1'b1, 1'b0, 1'b1, EXP_BANDS);
        repeat (3) tick();

        // A reset in mid-frame drops the frame and clears vec_48.
        run_pixels(0, 3000, 8'h80, 1'b0, 1'b0, 1'b0, 48'd0);
        expect_status(cyc, "before reset", last_vec, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        expect_status(cyc, "after reset", 48'd0, 1'b0, 1'b0);
        last_vec = '0;
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // Partial 0xFF frame, then restart with pix_sof. Sums left over from the
        // partial frame would overflow the equal-threshold compare.
        run_pixels(0, 5000, 8'hFF, 1'b0, 1'b0, 1'b0, 48'd0);
        run_pixels(0, N_PIX, 8'hFF, 1'b0, 1'b0, 1'b1, EXP_RESTART);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
